// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter for the single-port data memory (core C, debug/DMA D) with bounded locked bursts.
// Optional build macro DATA_ARB_ROUND_ROBIN_EN selects round-robin contests in ARB instead of fixed core priority.
module data_memory_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wren,
  input  logic [DATA_W-1:0] m_q,
  output logic              locked
);

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LOCKED = 2'd1,
    ST_YIELD  = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  state_t     state_q, state_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [7:0] lock_inc;
  logic       rd_c_q, rd_d_q;
  logic       core_wins;

`ifdef DATA_ARB_ROUND_ROBIN_EN
  // Records whether D won the most recent contest in ARB; the loser wins the next one.
  logic last_d_q, last_d_d;
  assign core_wins = last_d_q;
`else
  assign core_wins = 1'b1;
`endif

  assign lock_inc = (lock_cnt_q >= LOCK_MAX_C) ? lock_cnt_q : lock_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    c_gnt      = 1'b0;
    d_gnt      = 1'b0;
`ifdef DATA_ARB_ROUND_ROBIN_EN
    last_d_d   = last_d_q;
`endif
    if (!reset) begin
      case (state_q)
        ST_ARB: begin
          if (c_req && d_req) begin
            c_gnt = core_wins;
            d_gnt = !core_wins;
`ifdef DATA_ARB_ROUND_ROBIN_EN
            last_d_d = !core_wins;
`endif
          end else begin
            c_gnt = c_req;
            d_gnt = d_req;
          end
          // A one-beat limit exhausts the burst on its opening grant.
          if (d_gnt && d_lock) begin
            lock_cnt_d = 8'd1;
            state_d    = (LOCK_MAX_C <= 8'd1) ? ST_YIELD : ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          d_gnt = d_req;
          c_gnt = c_req && !d_req;
          if (d_gnt) begin
            lock_cnt_d = lock_inc;
            if (lock_inc >= LOCK_MAX_C) begin
              state_d = ST_YIELD;
            end else if (!d_lock) begin
              state_d    = ST_ARB;
              lock_cnt_d = 8'd0;
            end
          end
        end
        ST_YIELD: begin
          c_gnt      = c_req;
          d_gnt      = d_req && !c_req;
          state_d    = ST_ARB;
          lock_cnt_d = 8'd0;
        end
        default: begin
          state_d    = ST_ARB;
          lock_cnt_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_ARB;
      lock_cnt_q <= 8'd0;
      rd_c_q     <= 1'b0;
      rd_d_q     <= 1'b0;
`ifdef DATA_ARB_ROUND_ROBIN_EN
      last_d_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rd_c_q     <= c_gnt && !c_we;
      rd_d_q     <= d_gnt && !d_we;
`ifdef DATA_ARB_ROUND_ROBIN_EN
      last_d_q   <= last_d_d;
`endif
    end
  end

  assign c_stall  = c_req && !c_gnt;
  assign m_addr   = d_gnt ? d_addr : c_addr;
  assign m_wdata  = d_gnt ? d_wdata : c_wdata;
  assign m_wren   = (c_gnt && c_we) || (d_gnt && d_we);
  assign c_rvalid = rd_c_q;
  assign d_rvalid = rd_d_q;
  assign c_rdata  = m_q;
  assign d_rdata  = m_q;
  assign locked   = (state_q == ST_LOCKED);

endmodule
